// File: rtl/ppu_mem_arbiter.sv
// Three-way arbiter for the PPU memory port: render > CPU > loader, with a CPU
// starvation guard and a two-cycle, owner-tagged read return pipeline.
module ppu_mem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_gnt,
    output logic [DATA_W-1:0] r_rdata,
    output logic              r_rvalid,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,

    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_RENDER = 2'd1,
        TAG_CPU    = 2'd2
    } tag_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]        r_starve;
    logic [ADDR_W-1:0] r_last_addr;
    tag_t              r_tag;
    logic              r_valid_render;
    logic              r_valid_cpu;
    logic [DATA_W-1:0] r_data_render;
    logic [DATA_W-1:0] r_data_cpu;

    logic              w_cpu_force;
    logic              w_c_gnt;
    logic              w_r_gnt;
    logic              w_l_gnt;
    tag_t              w_tag_in;

    // Grants are gated by rst_n so every output sits at its reset value
    // throughout the reset window, even with requests still asserted.
    always_comb begin
        w_cpu_force = c_req && (r_starve >= LIMIT);
        w_c_gnt     = rst_n && c_req && (!r_req || w_cpu_force);
        w_r_gnt     = rst_n && r_req && !w_c_gnt;
        w_l_gnt     = rst_n && l_req && !r_req && !c_req;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        mem_addr  = r_last_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        w_tag_in  = TAG_NONE;
        if (w_r_gnt) begin
            mem_addr = r_addr;
            w_tag_in = TAG_RENDER;
        end else if (w_c_gnt) begin
            mem_addr  = c_addr;
            mem_we    = c_we;
            mem_wdata = c_wdata;
            if (!c_we) begin
                w_tag_in = TAG_CPU;
            end
        end else if (w_l_gnt) begin
            mem_addr  = l_addr;
            mem_we    = 1'b1;
            mem_wdata = l_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve    <= 8'd0;
            r_last_addr <= '0;
        end else begin
            if (w_c_gnt) begin
                r_starve <= 8'd0;
            end else if (c_req && (r_starve != 8'hFF)) begin
                r_starve <= r_starve + 8'd1;
            end
            if (w_r_gnt || w_c_gnt || w_l_gnt) begin
                r_last_addr <= mem_addr;
            end
        end
    end

    // Stage 1 holds the owner of the read issued last cycle; stage 2 captures
    // the RAM data into that owner's register alongside its valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag          <= TAG_NONE;
            r_valid_render <= 1'b0;
            r_valid_cpu    <= 1'b0;
            r_data_render  <= '0;
            r_data_cpu     <= '0;
        end else begin
            r_tag          <= w_tag_in;
            r_valid_render <= (r_tag == TAG_RENDER);
            r_valid_cpu    <= (r_tag == TAG_CPU);
            if (r_tag == TAG_RENDER) begin
                r_data_render <= mem_rdata;
            end
            if (r_tag == TAG_CPU) begin
                r_data_cpu <= mem_rdata;
            end
        end
    end

    assign r_gnt    = w_r_gnt;
    assign c_gnt    = w_c_gnt;
    assign l_gnt    = w_l_gnt;
    assign r_rdata  = r_data_render;
    assign r_rvalid = r_valid_render;
    assign c_rdata  = r_data_cpu;
    assign c_rvalid = r_valid_cpu;

endmodule

// File: doc/ppu_mem_arbiter.md
# ppu_mem_arbiter

Three-way arbiter for the single PPU memory port (pattern/nametable/palette store behind the PPU memory wrapper). It shares the port between the PPU render fetch engine, CPU-side PPUDATA accesses, and the boot-time CHR loader. It issues at most one access per `clk` and returns read data with a fixed two-cycle latency, tagged to the requester that issued it. A starvation guard guarantees CPU progress while rendering.

## Interface
Parameters:
- `ADDR_W`, 14, memory address width
- `DATA_W`, 8, memory data width
- `STARVE_LIMIT`, 8, consecutive denied CPU cycles before the CPU is forced through (legal range 1..255)

Ports:
- `clk`  in  1  PPU system clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `r_req`  in  1  render read request
- `r_addr`  in  ADDR_W  render read address
- `r_gnt`  out  1  render granted this cycle
- `r_rdata`  out  DATA_W  render read data
- `r_rvalid`  out  1  render read data valid (1-cycle pulse)
- `c_req`  in  1  CPU access request
- `c_we`  in  1  CPU access is a write
- `c_addr`  in  ADDR_W  CPU address
- `c_wdata`  in  DATA_W  CPU write data
- `c_gnt`  out  1  CPU granted this cycle
- `c_rdata`  out  DATA_W  CPU read data
- `c_rvalid`  out  1  CPU read data valid (1-cycle pulse)
- `l_req`  in  1  loader write request
- `l_addr`  in  ADDR_W  loader address
- `l_wdata`  in  DATA_W  loader write data
- `l_gnt`  out  1  loader granted this cycle
- `mem_addr`  out  ADDR_W  memory address
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data; valid in the cycle after the address is presented (synchronous RAM)

## Operation
- Grants are combinational from current requests and registered state. At most one of `r_gnt`/`c_gnt`/`l_gnt` is high in any cycle.
- Default priority: render > CPU > loader. The loader is granted only when neither `r_req` nor `c_req` is high.
- Starvation counter `starve` (8 bits): increments each cycle `c_req`=1 and `c_gnt`=0, and clears on `c_gnt`.
  - When `starve` ≥ `STARVE_LIMIT` and `c_req`=1, the CPU wins over render for that cycle.
  - The counter saturates at 255.
- Requester contract: `req` and its address, data and `we` stay stable until the cycle `gnt` is high. A request is consumed in its `gnt` cycle. A requester may hold `req` high for back-to-back accesses.
- Memory port: in the grant cycle, `mem_addr`/`mem_we`/`mem_wdata` are driven from the granted requester (combinational mux).
  - Render accesses are always reads (`mem_we`=0).
  - Loader accesses are always writes.
  - The CPU write enable is taken from `c_we`.
  - With no grant: `mem_we`=0, `mem_addr` holds its last granted value, `mem_wdata`=0.
- Read return pipeline, two stages:
  - Stage 1 registers the owner tag (none/render/CPU) for a read granted in cycle T.
  - In cycle T+1, `mem_rdata` is captured into the owner's data register and stage 2 registers the valid bit.
  - In cycle T+2, the owner's `rvalid` pulses and its `rdata` presents the data.
  - `rdata` holds its value until that requester's next read completes.
- Writes produce no `rvalid`.
- The pipeline accepts a new read every cycle, so grants in T, T+1, T+2 give `rvalid` in T+2, T+3, T+4, with no bubbles.

## Timing
- Reset (`rst_n`=0, asynchronous): all grants 0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `r_rdata`=`c_rdata`=0, `r_rvalid`=`c_rvalid`=0, `starve`=0, pipeline tags cleared.
- Grant latency: 0 cycles from request under no contention.
- Read latency: exactly 2 cycles from the grant cycle to the `rvalid` cycle.
- Reset asserted mid-operation: reads in flight are discarded and no `rvalid` is emitted after reset release.
- First grant is possible in the first rising edge's cycle after `rst_n` deasserts.
- Simultaneous `r_req`+`c_req` with `starve` < limit: render wins and `starve` increments.
- With `c_req` held continuously against continuous `r_req`: the CPU is granted exactly once every `STARVE_LIMIT`+1 cycles.
- Simultaneous all three requests: the loader waits. The loader can starve indefinitely; this is intended, since it runs only while rendering is disabled.

## Test plan
- Reset then single CPU read of 0x23C0 (memory preloaded 0x5A): `c_gnt` in T, `mem_addr`=0x23C0, `c_rvalid`=1 with `c_rdata`=0x5A in T+2; `r_rvalid` stays 0.
- Render reads 0x0000,0x0001,0x0002 back-to-back: three consecutive `r_gnt`, then three consecutive `r_rvalid` beginning T+2 with matching data in order.
- `r_req` and `c_req` held high continuously, `STARVE_LIMIT`=8: `c_gnt` at cycle 8 after start and every 9th cycle after; render is granted all other cycles.
- Loader writes 0xAA to 0x1FFF while `c_req` is asserted: CPU granted first; `l_gnt` follows the cycle `c_req` drops; subsequent CPU read of 0x1FFF returns 0xAA.
- CPU write 0x3F00←0x0F then immediate CPU read of 0x3F00: write grant T (`mem_we`=1), read grant T+1, `c_rvalid` T+3 with 0x0F.
- Assert `rst_n`=0 one cycle after a render read grant: `r_rvalid` never pulses; all outputs at reset values within the reset cycle.
